traffic_phase_timer: RTL and testbench

- Generates the single-cycle `en` advance pulse that steps the traffic-light controller from phase to phase.
- Decodes the controller's current phase from its light outputs and loads that phase's dwell time into a down-counter.
- Pulses `en` when the dwell expires, checks that the controller actually advanced, and counts completed main cycles.
- Sits between the system tick clock and the controller; its `en` drives the controller's phase clock.

---
 rtl/traffic_phase_timer.sv | 134 +++++++++++++
 tb/tb_traffic_phase_timer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic-light controller: decodes the current phase from the
// light outputs, counts its dwell down, and issues a one-clock advance pulse on en.
module traffic_phase_timer #(
    parameter int          CNT_W         = 16,
    parameter int unsigned T_MAIN_GREEN  = 30,
    parameter int unsigned T_MAIN_YELLOW = 5,
    parameter int unsigned T_ALL_RED     = 2,
    parameter int unsigned T_SIDE_GREEN  = 20,
    parameter int unsigned T_SIDE_YELLOW = 5,
    parameter int unsigned T_PED         = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             MG,
    input  logic             MY,
    input  logic             MR,
    input  logic             SG,
    input  logic             SY,
    input  logic             SR,
    input  logic             pedLight,
    input  logic             newCycle,
    output logic             en,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             fault,
    output logic [7:0]       cycle_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        COUNT  = 3'd2,
        PULSE  = 3'd3,
        SETTLE = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [2:0] PH_INVALID = 3'd7;

    state_t           state, state_next;
    logic [2:0]       prev_phase, prev_phase_next;
    logic [CNT_W-1:0] remaining_next;
    logic [7:0]       cycle_count_next;
    logic [1:0]       main_lit, side_lit;

    // Zero-length dwells would make COUNT wait a full counter wrap, so clamp to one.
    function automatic logic [CNT_W-1:0] dwell_of(input logic [2:0] p);
        int unsigned t;
        case (p)
            3'd0:    t = T_MAIN_GREEN;
            3'd1:    t = T_MAIN_YELLOW;
            3'd2:    t = T_ALL_RED;
            3'd3:    t = T_SIDE_GREEN;
            3'd4:    t = T_SIDE_YELLOW;
            3'd5:    t = T_PED;
            default: t = 1;
        endcase
        if (t == 0) t = 1;
        return t[CNT_W-1:0];
    endfunction

    always_comb begin
        main_lit = {1'b0, MG} + {1'b0, MY} + {1'b0, MR};
        side_lit = {1'b0, SG} + {1'b0, SY} + {1'b0, SR};
        phase    = PH_INVALID;
        if (main_lit == 2'd1 && side_lit == 2'd1) begin
            if (MG && SR)      phase = 3'd0;
            else if (MY && SR) phase = 3'd1;
            else if (MR && SR) phase = pedLight ? 3'd5 : 3'd2;
            else if (MR && SG) phase = 3'd3;
            else if (MR && SY) phase = 3'd4;
        end
    end

    always_comb begin
        state_next       = state;
        remaining_next   = remaining;
        prev_phase_next  = prev_phase;
        cycle_count_next = cycle_count;
        case (state)
            IDLE: if (run) state_next = LOAD;
            LOAD: begin
                if (phase == PH_INVALID || (phase == prev_phase && prev_phase != PH_INVALID)) begin
                    state_next     = FAULT;
                    remaining_next = '0;
                end else begin
                    state_next      = COUNT;
                    remaining_next  = dwell_of(phase);
                    prev_phase_next = phase;
                end
                if (phase == 3'd0 && newCycle && prev_phase != PH_INVALID)
                    cycle_count_next = cycle_count + 8'd1;
            end
            COUNT: begin
                if (run) begin
                    if (remaining == CNT_W'(1)) begin
                        state_next     = PULSE;
                        remaining_next = '0;
                    end else begin
                        remaining_next = remaining - CNT_W'(1);
                    end
                end
            end
            PULSE:  state_next = SETTLE;
            SETTLE: state_next = LOAD;
            FAULT:  remaining_next = '0;
            default: begin
                state_next     = FAULT;
                remaining_next = '0;
            end
        endcase
    end

    // en and fault are flopped from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            en          <= 1'b0;
            remaining   <= '0;
            fault       <= 1'b0;
            cycle_count <= 8'd0;
            prev_phase  <= PH_INVALID;
        end else begin
            state       <= state_next;
            en          <= (state_next == PULSE);
            remaining   <= remaining_next;
            fault       <= (state_next == FAULT);
            cycle_count <= cycle_count_next;
            prev_phase  <= prev_phase_next;
        end
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: a small controller model steps the lights on each en
// pulse and expected pulse spacings are queued and compared as pulses arrive.
module tb_traffic_phase_timer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             run = 1'b0;
    logic             MG = 1'b0, MY = 1'b0, MR = 1'b0;
    logic             SG = 1'b0, SY = 1'b0, SR = 1'b0;
    logic             pedLight = 1'b0, newCycle = 1'b0;
    logic             en;
    logic [2:0]       phase;
    logic [CNT_W-1:0] remaining;
    logic             fault;
    logic [7:0]       cycle_count;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_en = 0;
    logic [15:0]  exp_q[$];

    traffic_phase_timer dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .MG(MG), .MY(MY), .MR(MR), .SG(SG), .SY(SY), .SR(SR),
        .pedLight(pedLight), .newCycle(newCycle),
        .en(en), .phase(phase), .remaining(remaining), .fault(fault),
        .cycle_count(cycle_count)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- controller model / drivers ----------------
    function automatic int dwell(input int p);
        case (p)
            0: return 30;
            1: return 5;
            2: return 2;
            3: return 20;
            4: return 5;
            5: return 15;
            default: return 1;
        endcase
    endfunction

    task automatic set_lights(input int p);
        {MG, MY, MR, SG, SY, SR, pedLight} = 7'b0;
        case (p)
            0: begin MG = 1; SR = 1; end
            1: begin MY = 1; SR = 1; end
            2: begin MR = 1; SR = 1; end
            3: begin MR = 1; SG = 1; end
            4: begin MR = 1; SY = 1; end
            5: begin MR = 1; SR = 1; pedLight = 1; end
            default: ;
        endcase
        newCycle = (p == 0);
    endtask

    task automatic next_en(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!en && n < 400);
        ok = en;
    endtask

    // Controller advances to phase p on the en just seen; next en is dwell(p)+3 later.
    task automatic step_to(input int p);
        bit          ok;
        int          got;
        logic [15:0] exp;
        set_lights(p);
        exp_q.push_back(16'(dwell(p) + 3));
        next_en(ok);
        got = cyc - last_en;
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got != int'(exp)) begin
            errors++;
            $display("FAIL spacing_to_phase%0d got %0d expected %0d (en_seen=%0b)", p, got, exp, ok);
        end
        last_en = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [6:0] pat [9];
        logic [2:0] exp_ph [9];
        pat    = '{7'b1000010, 7'b0100010, 7'b0010010, 7'b0011000, 7'b0010100,
                   7'b0010011, 7'b1010010, 7'b1000110, 7'b0000000};
        exp_ph = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd7, 3'd7};
        reset_n = 0; run = 0;
        set_lights(0);
        repeat (3) @(negedge clk);
        checks++;
        if (en !== 1'b0 || remaining !== '0 || fault !== 1'b0 || cycle_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_values en=%0b rem=%0d fault=%0b cc=%0d expected 0 0 0 0",
                     en, remaining, fault, cycle_count);
        end
        for (int i = 0; i < 9; i++) begin
            logic [6:0] v;
            v = pat[i];
            {MG, MY, MR, SG, SY, SR, pedLight} = v;
            #1;
            checks++;
            if (phase !== exp_ph[i]) begin
                errors++;
                $display("FAIL decode_%b got %0d expected %0d", v, phase, exp_ph[i]);
            end
        end
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_first_load;
        bit          ok;
        int          l, got;
        logic [15:0] exp;
        set_lights(0);
        run = 1;
        @(negedge clk);
        l = cyc;
        @(negedge clk);
        checks++;
        if (remaining !== 16'd30) begin
            errors++;
            $display("FAIL first_load_remaining got %0d expected 30", remaining);
        end
        exp_q.push_back(16'd31);
        next_en(ok);
        got = cyc - l;
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got != int'(exp)) begin
            errors++;
            $display("FAIL first_en_latency got %0d expected %0d", got, exp);
        end
        checks++;
        if (cycle_count !== 8'd0) begin
            errors++;
            $display("FAIL first_load_cycle_count got %0d expected 0", cycle_count);
        end
        last_en = cyc;
    endtask

    task automatic test_full_cycle;
        step_to(1); step_to(2); step_to(3); step_to(4); step_to(2); step_to(0);
        checks++;
        if (cycle_count !== 8'd1) begin
            errors++;
            $display("FAIL full_cycle_count got %0d expected 1", cycle_count);
        end
    endtask

    task automatic test_ped_cycle;
        step_to(1); step_to(2); step_to(3); step_to(4); step_to(2); step_to(5); step_to(0);
        checks++;
        if (cycle_count !== 8'd2) begin
            errors++;
            $display("FAIL ped_cycle_count got %0d expected 2", cycle_count);
        end
    endtask

    task automatic test_reset_in_pulse;
        checks++;
        if (en !== 1'b1) begin
            errors++;
            $display("FAIL pulse_present en got %0b expected 1", en);
        end
        reset_n = 0;
        run = 0;
        @(negedge clk);
        checks++;
        if (en !== 1'b0 || remaining !== '0 || fault !== 1'b0 || cycle_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_in_pulse en=%0b rem=%0d fault=%0b cc=%0d expected 0 0 0 0",
                     en, remaining, fault, cycle_count);
        end
        reset_n = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (en !== 1'b0 || remaining !== '0) begin
            errors++;
            $display("FAIL idle_after_reset en=%0b rem=%0d expected 0 0", en, remaining);
        end
    endtask

    task automatic test_run_freeze;
        bit          ok, found;
        int          l, got;
        logic [15:0] exp;
        set_lights(0);
        run = 1;
        @(negedge clk);
        l = cyc;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (remaining == 16'd12) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL freeze_reach12 remaining got %0d expected 12", remaining);
        end
        run = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (remaining !== 16'd12 || en !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold remaining got %0d en %0b expected 12 0", remaining, en);
        end
        run = 1;
        exp_q.push_back(16'd41);
        next_en(ok);
        got = cyc - l;
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got != int'(exp)) begin
            errors++;
            $display("FAIL freeze_en_latency got %0d expected %0d", got, exp);
        end
        last_en = cyc;
    endtask

    task automatic test_stuck;
        int highs;
        repeat (3) @(negedge clk);
        checks++;
        if (fault !== 1'b1 || remaining !== '0 || en !== 1'b0) begin
            errors++;
            $display("FAIL stuck_fault fault=%0b rem=%0d en=%0b expected 1 0 0", fault, remaining, en);
        end
        highs = 0;
        repeat (50) begin
            @(negedge clk);
            if (en) highs++;
        end
        checks++;
        if (highs != 0 || fault !== 1'b1) begin
            errors++;
            $display("FAIL stuck_no_en en_highs got %0d fault %0b expected 0 1", highs, fault);
        end
        reset_n = 0;
        run = 0;
        @(negedge clk);
        checks++;
        if (fault !== 1'b0 || remaining !== '0) begin
            errors++;
            $display("FAIL stuck_reset fault=%0b rem=%0d expected 0 0", fault, remaining);
        end
        reset_n = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (fault !== 1'b0 || en !== 1'b0) begin
            errors++;
            $display("FAIL stuck_idle fault=%0b en=%0b expected 0 0", fault, en);
        end
    endtask

    task automatic test_illegal;
        {MG, MY, MR, SG, SY, SR, pedLight} = 7'b1010010;
        newCycle = 0;
        #1;
        checks++;
        if (phase !== 3'd7) begin
            errors++;
            $display("FAIL illegal_phase got %0d expected 7", phase);
        end
        run = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (fault !== 1'b1 || en !== 1'b0 || phase !== 3'd7) begin
            errors++;
            $display("FAIL illegal_fault fault=%0b en=%0b phase=%0d expected 1 0 7", fault, en, phase);
        end
    endtask

    initial begin
        test_reset;
        test_first_load;
        test_full_cycle;
        test_ped_cycle;
        test_reset_in_pulse;
        test_run_freeze;
        test_stuck;
        test_illegal;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
